// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and helpers for the program-memory loader.
//   pmem_state_e : loader FSM states (IDLE / LOAD / DONE)
//   pmem_nb      : bytes per instruction word, ceil(iw / bw)
//   pmem_even_par: even-parity bit over a zero-extended word
package pmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } pmem_state_e;

   function automatic int pmem_nb(input int iw, input int bw);
      return (iw + bw - 1) / bw;
   endfunction

   // Callers zero-extend; the padding does not change the parity.
   function automatic logic pmem_even_par(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/pmem_loader_if.sv
// pmem_loader_if: valid/ready byte stream that feeds program words into
// the loader.
//   ld_valid : source has a byte on ld_data
//   ld_data  : stream byte, least-significant byte of a word first
//   ld_ready : loader accepts the byte this cycle
// master = byte source (UART/SPI bridge), slave = pmem_loader.
interface pmem_loader_if #(
   parameter int BW = 8
) ();
   logic          ld_valid;
   logic [BW-1:0] ld_data;
   logic          ld_ready;

   modport master (output ld_valid, output ld_data, input ld_ready);
   modport slave  (input ld_valid, input ld_data, output ld_ready);
endinterface

// File: rtl/pmem_word_asm.sv
// pmem_word_asm: assembles NB stream bytes into one instruction word.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart assembly at byte 0 (start of a load)
//   accept     : a byte is taken this cycle
//   byte_in    : the byte being taken
//   word       : assembled word including the byte taken this cycle
//   word_stb   : the byte taken this cycle completes the word
// Byte k lands in bits [k*BW +: BW]; bits of the last byte above IW
// are dropped.
module pmem_word_asm
   import pmem_pkg::*;
#(
   parameter int IW = 12,
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          accept,
   input  logic [BW-1:0] byte_in,
   output logic [IW-1:0] word,
   output logic          word_stb
);

   localparam int NB  = pmem_nb(IW, BW);
   localparam int IXW = (NB > 1) ? $clog2(NB) : 1;

   logic [IXW-1:0] idx;
   logic [IW-1:0]  wreg;
   logic [IW-1:0]  word_nxt;
   logic           last;

   always_comb begin
      word_nxt = wreg;
      for (int j = 0; j < IW; j++) begin
         if (j / BW == int'(idx)) word_nxt[j] = byte_in[j % BW];
      end
   end

   assign last     = (int'(idx) == NB - 1);
   assign word_stb = accept & last;
   assign word     = word_nxt;

   // Every byte position is overwritten each word, so wreg needs no clearing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx  <= '0;
         wreg <= '0;
      end else if (clr) begin
         idx <= '0;
      end else if (accept) begin
         wreg <= word_nxt;
         idx  <= last ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/pmem_loader.sv
// pmem_loader: program memory (2**AW x IW) with a registered fetch port and
// a byte-stream loader.
//   clk, rst_n            : clock, async active-low reset
//   fetch_en, fetch_addr  : fetch request; instr/instr_vld one cycle later
//   instr, instr_vld      : registered fetch result (0 when blocked)
//   par_err               : parity mismatch on instr (0 without parity)
//   load_start            : starts a load, samples load_base/load_cnt
//   load_base, load_cnt   : first word address, word count minus 1
//   ld (slave)            : valid/ready byte stream
//   load_busy, load_done  : load in progress, end-of-load pulse
// Build option: PMEM_PARITY_EN adds an even-parity bit per word.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | no load; fetches served
//   LOAD    | accepting bytes, writing a word per NB bytes
//   DONE    | one-cycle load_done pulse, fetch still blocked
module pmem_loader
   import pmem_pkg::*;
#(
   parameter int IW = 12,
   parameter int AW = 8,
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          fetch_en,
   input  logic [AW-1:0] fetch_addr,
   output logic [IW-1:0] instr,
   output logic          instr_vld,
   output logic          par_err,
   input  logic          load_start,
   input  logic [AW-1:0] load_base,
   input  logic [AW-1:0] load_cnt,
   pmem_loader_if.slave  ld,
   output logic          load_busy,
   output logic          load_done
);

`ifdef PMEM_PARITY_EN
   localparam int MW = IW + 1;
`else
   localparam int MW = IW;
`endif

   logic [MW-1:0] mem [0:(2**AW)-1];

   pmem_state_e   state;
   logic [AW-1:0] waddr;
   logic [AW-1:0] wcnt;
   logic          ready_q;
   logic          accept;
   logic          clr;
   logic          word_stb;
   logic [IW-1:0] word;
   logic [MW-1:0] wr_data;
   logic [MW-1:0] rd_data;

   assign ld.ld_ready = ready_q;
   assign accept      = ld.ld_valid & ready_q;
   assign clr         = (state == ST_IDLE) & load_start;

   pmem_word_asm #(
      .IW (IW),
      .BW (BW)
   ) u_word_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .accept   (accept),
      .byte_in  (ld.ld_data),
      .word     (word),
      .word_stb (word_stb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         waddr     <= '0;
         wcnt      <= '0;
         ready_q   <= 1'b0;
         load_busy <= 1'b0;
         load_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_start) begin
                  state     <= ST_LOAD;
                  waddr     <= load_base;
                  wcnt      <= load_cnt;
                  ready_q   <= 1'b1;
                  load_busy <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (word_stb) begin
                  waddr <= waddr + 1'b1;
                  if (wcnt == '0) begin
                     state     <= ST_DONE;
                     ready_q   <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     wcnt <= wcnt - 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               load_done <= 1'b0;
               load_busy <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               ready_q   <= 1'b0;
               load_busy <= 1'b0;
               load_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef PMEM_PARITY_EN
   assign wr_data = {pmem_even_par(64'(word)), word};
`else
   assign wr_data = word;
`endif

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (word_stb) mem[waddr] <= wr_data;
   end

   assign rd_data = mem[fetch_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr     <= '0;
         instr_vld <= 1'b0;
      end else if (fetch_en && !load_busy) begin
         instr     <= rd_data[IW-1:0];
         instr_vld <= 1'b1;
      end else begin
         instr     <= '0;
         instr_vld <= 1'b0;
      end
   end

`ifdef PMEM_PARITY_EN
   logic par_q;

   // Stored bit makes the whole word even, so odd XOR means corruption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        par_q <= 1'b0;
      else if (fetch_en && !load_busy)   par_q <= ^rd_data;
      else                               par_q <= 1'b0;
   end

   assign par_err = par_q;
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_loader.sv
module tb_pmem_loader;

   localparam int IW = 12;
   localparam int AW = 8;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fetch_en = 1'b0;
   logic [AW-1:0] fetch_addr = '0;
   logic [IW-1:0] instr;
   logic          instr_vld;
   logic          par_err;
   logic          load_start = 1'b0;
   logic [AW-1:0] load_base = '0;
   logic [AW-1:0] load_cnt = '0;
   logic          load_busy;
   logic          load_done;

   pmem_loader_if #(.BW(BW)) ld ();

   pmem_loader #(
      .IW (IW),
      .AW (AW),
      .BW (BW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fetch_en   (fetch_en),
      .fetch_addr (fetch_addr),
      .instr      (instr),
      .instr_vld  (instr_vld),
      .par_err    (par_err),
      .load_start (load_start),
      .load_base  (load_base),
      .load_cnt   (load_cnt),
      .ld         (ld),
      .load_busy  (load_busy),
      .load_done  (load_done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: word contents per address, plus which addresses are defined.
   logic [IW-1:0] ref_mem [256];
   bit            ref_known [256];
   logic [7:0]    tx_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random(input int n_words);
      tx_q.delete();
      for (int i = 0; i < 2 * n_words; i++) tx_q.push_back(8'($urandom));
   endtask

   // Two bytes per word, low byte first, upper nibble of the high byte dropped.
   task automatic ref_write(input logic [7:0] base, input int n_words);
      for (int i = 0; i < n_words; i++) begin
         int a;
         a = (int'(base) + i) % 256;
         ref_mem[a]   = {tx_q[2*i+1][3:0], tx_q[2*i]};
         ref_known[a] = 1'b1;
      end
   endtask

   task automatic fetch_check(input logic [7:0] a);
      @(negedge clk);
      fetch_en   = 1'b1;
      fetch_addr = a;
      @(negedge clk);
      fetch_en = 1'b0;
      check($sformatf("instr@%02h", a), 32'(instr), 32'(ref_mem[a]));
      check("instr_vld", 32'(instr_vld), 32'd1);
      check("par_err_clean", 32'(par_err), 32'd0);
   endtask

   // Streams tx_q as a load. abort_after >= 0 resets the DUT after that
   // many accepted bytes; dup_start fires a second load_start mid-load.
   task automatic run_load(input logic [7:0] base, input logic [7:0] cnt,
                           input int abort_after, input bit dup_start);
      int nbytes;
      int sent;
      int cyc;
      nbytes = tx_q.size();
      sent   = 0;
      cyc    = 0;
      @(negedge clk);
      load_start = 1'b1;
      load_base  = base;
      load_cnt   = cnt;
      fetch_en   = 1'b1;
      fetch_addr = 8'($urandom);
      @(negedge clk);
      load_start = 1'b0;
      check("busy_rise", 32'(load_busy), 32'd1);
      check("ready_rise", 32'(ld.ld_ready), 32'd1);
      while (sent < nbytes && cyc < 2000) begin
         if (abort_after >= 0 && sent == abort_after) break;
         ld.ld_valid = ($urandom_range(0, 99) < 70);
         ld.ld_data  = tx_q[sent];
         if (dup_start && cyc == 3) begin
            load_start = 1'b1;
            load_base  = base + 8'h33;
            load_cnt   = cnt + 8'd3;
         end
         @(negedge clk);
         load_start = 1'b0;
         if (ld.ld_valid) sent++;
         ld.ld_valid = 1'b0;
         check("fetch_blocked", {19'd0, instr_vld, instr}, 32'd0);
         if (sent < nbytes) check("no_early_done", 32'(load_done), 32'd0);
         cyc++;
      end
      if (cyc >= 2000) check("load_timeout", 32'd0, 32'd1);
      if (abort_after >= 0) begin
         rst_n = 1'b0;
         #1;
         check("rst_outputs", {16'd0, ld.ld_ready, load_busy, load_done,
                              par_err, instr_vld, instr}, 32'd0);
         @(negedge clk);
         rst_n    = 1'b1;
         fetch_en = 1'b0;
         ref_write(base, abort_after / 2);
         return;
      end
      check("done_pulse", 32'(load_done), 32'd1);
      check("busy_in_done", 32'(load_busy), 32'd1);
      check("ready_in_done", 32'(ld.ld_ready), 32'd0);
      ref_write(base, int'(cnt) + 1);
      @(negedge clk);
      check("done_fall", 32'(load_done), 32'd0);
      check("busy_fall", 32'(load_busy), 32'd0);
      check("blocked_after_done", {19'd0, instr_vld, instr}, 32'd0);
      fetch_en = 1'b0;
   endtask

   initial begin
      ld.ld_valid = 1'b0;
      ld.ld_data  = '0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]   = '0;
         ref_known[i] = 1'b0;
      end

      repeat (2) @(negedge clk);
      check("reset_outputs", {16'd0, ld.ld_ready, load_busy, load_done,
                             par_err, instr_vld, instr}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_idle", 32'(ld.ld_ready), 32'd0);

      tx_q = '{8'h34, 8'h02, 8'hCD, 8'hFB};
      run_load(8'h10, 8'd1, -1, 1'b0);
      @(negedge clk);
      fetch_en   = 1'b1;
      fetch_addr = 8'h11;
      @(negedge clk);
      fetch_en = 1'b0;
      check("basic_11", 32'(instr), 32'h0BCD);
      check("basic_vld", 32'(instr_vld), 32'd1);
      fetch_check(8'h10);

`ifdef PMEM_PARITY_EN
      dut.mem[8'h10] = dut.mem[8'h10] ^ 13'h008;
      @(negedge clk);
      fetch_en   = 1'b1;
      fetch_addr = 8'h10;
      @(negedge clk);
      fetch_en = 1'b0;
      check("par_instr", 32'(instr), 32'h023C);
      check("par_err_set", 32'(par_err), 32'd1);
      ref_known[8'h10] = 1'b0;
      fetch_check(8'h11);
`endif

      @(negedge clk);
      fetch_en = 1'b0;
      @(negedge clk);
      check("fetch_idle", {19'd0, instr_vld, instr}, 32'd0);

      fill_random(1);
      run_load(8'h01, 8'd0, -1, 1'b0);
      fill_random(2);
      run_load(8'hFF, 8'd1, -1, 1'b0);
      fetch_check(8'hFF);
      fetch_check(8'h00);
      fetch_check(8'h01);

      fill_random(4);
      run_load(8'h80, 8'd3, -1, 1'b1);
      for (int a = 8'h80; a <= 8'h83; a++) fetch_check(8'(a));

      fill_random(4);
      run_load(8'h40, 8'd3, 5, 1'b0);
      fill_random(1);
      run_load(8'h42, 8'd0, -1, 1'b0);
      for (int a = 8'h40; a <= 8'h42; a++) fetch_check(8'(a));

      for (int k = 0; k < 6; k++) begin
         logic [7:0] b;
         logic [7:0] c;
         b = 8'($urandom);
         c = 8'($urandom_range(0, 5));
         fill_random(int'(c) + 1);
         run_load(b, c, -1, 1'b0);
      end

      for (int a = 0; a < 256; a++) begin
         if (ref_known[a]) fetch_check(8'(a));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
